// File: rtl/des_top.sv
// Iterative DES engine: one 64-bit block, one Feistel round per clock.
// After each reset release: LOAD, 16 rounds, then DONE holds the result.
// Optional feature macro DES_DECRYPT_EN adds a decrypt input sampled at LOAD.
module des_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:63] plainText,
  input  logic [0:63] key,
`ifdef DES_DECRYPT_EN
  input  logic        decrypt,
`endif
  output logic [63:0] encrypted,
  output logic        completed
);

  typedef enum logic [1:0] {StLoad, StRound, StDone} state_e;

  // Table entries are 1-based DES bit numbers, MSB of each vector is DES bit 1.
  localparam int unsigned IpTbl [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

  localparam int unsigned FpTbl [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned ETbl [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int unsigned PTbl [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int unsigned Pc1Tbl [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned Pc2Tbl [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Indexed by {row, col} = {b1, b6, b2..b5} of the 6-bit S-box input.
  localparam logic [3:0] SBox [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

  function automatic logic [63:0] perm_ip(input logic [63:0] v);
    for (int j = 0; j < 64; j++) perm_ip[63-j] = v[64-IpTbl[j]];
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] v);
    for (int j = 0; j < 64; j++) perm_fp[63-j] = v[64-FpTbl[j]];
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] v);
    for (int j = 0; j < 56; j++) perm_pc1[55-j] = v[64-Pc1Tbl[j]];
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] v);
    for (int j = 0; j < 48; j++) perm_pc2[47-j] = v[56-Pc2Tbl[j]];
  endfunction

  function automatic logic [47:0] expand(input logic [31:0] v);
    for (int j = 0; j < 48; j++) expand[47-j] = v[32-ETbl[j]];
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] v);
    for (int j = 0; j < 32; j++) perm_p[31-j] = v[32-PTbl[j]];
  endfunction

  // Round function f(R, K) = P(S(E(R) xor K)).
  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [5:0]  six;
    logic [31:0] s;
    x = expand(r) ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      six           = x[47-6*i -: 6];
      s[31-4*i -: 4] = SBox[i][{six[5], six[0], six[4:1]}];
    end
    return perm_p(s);
  endfunction

  // Rotation toward DES bit 1 (the MSB) is a left rotate.
  function automatic logic [27:0] rotl(input logic [27:0] v, input logic [1:0] n);
    case (n)
      2'd1:    rotl = {v[26:0], v[27]};
      2'd2:    rotl = {v[25:0], v[27:26]};
      default: rotl = v;
    endcase
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic [1:0] n);
    case (n)
      2'd1:    rotr = {v[0], v[27:1]};
      2'd2:    rotr = {v[1:0], v[27:2]};
      default: rotr = v;
    endcase
  endfunction

  state_e      state_q;
  logic [4:0]  round_q;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic        dec_mode;

  logic [1:0]  shift_amt;
  logic [27:0] c_next, d_next;
  logic [47:0] subkey;
  logic [31:0] f_out;

`ifdef DES_DECRYPT_EN
  logic decrypt_q;
  assign dec_mode = decrypt_q;
`else
  assign dec_mode = 1'b0;
`endif

  // Key-schedule step and round function for the round held in round_q.
  always_comb begin
    shift_amt = 2'd2;
    if (dec_mode) begin
      // Walks the schedule backwards: K16 is C0/D0 itself, then undo each shift.
      if (round_q == 5'd1) shift_amt = 2'd0;
      else if (round_q == 5'd2 || round_q == 5'd9 || round_q == 5'd16) shift_amt = 2'd1;
      c_next = rotr(c_q, shift_amt);
      d_next = rotr(d_q, shift_amt);
    end else begin
      if (round_q == 5'd1 || round_q == 5'd2 || round_q == 5'd9 || round_q == 5'd16) begin
        shift_amt = 2'd1;
      end
      c_next = rotl(c_q, shift_amt);
      d_next = rotl(d_q, shift_amt);
    end
    subkey = perm_pc2({c_next, d_next});
    f_out  = feistel(r_q, subkey);
  end

  // Control FSM plus datapath registers; outputs only change on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StLoad;
      round_q   <= '0;
      l_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      encrypted <= '0;
      completed <= 1'b0;
`ifdef DES_DECRYPT_EN
      decrypt_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StLoad: begin
          {l_q, r_q} <= perm_ip(plainText);
          {c_q, d_q} <= perm_pc1(key);
          round_q    <= 5'd1;
          state_q    <= StRound;
`ifdef DES_DECRYPT_EN
          decrypt_q  <= decrypt;
`endif
        end
        StRound: begin
          l_q     <= r_q;
          r_q     <= l_q ^ f_out;
          c_q     <= c_next;
          d_q     <= d_next;
          round_q <= round_q + 5'd1;
          if (round_q == 5'd16) state_q <= StDone;
        end
        StDone: begin
          // Halves are swapped before FP; after that the state is frozen.
          if (!completed) begin
            encrypted <= perm_fp({r_q, l_q});
            completed <= 1'b1;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_des_top.sv
// Bench for des_top: random and known-answer blocks, scoreboard queue plus monitor.
module tb_des_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:63] plainText = '0;
  logic [0:63] key = '0;
`ifdef DES_DECRYPT_EN
  logic        decrypt = 1'b0;
  localparam bit HasDec = 1'b1;
`else
  localparam bit HasDec = 1'b0;
`endif
  logic [63:0] encrypted;
  logic        completed;

  int          tests = 0;
  int          fails = 0;
  int          cyc;
  logic [63:0] exp_q[$];
  logic [63:0] last_ct = '0;
  bit          seen_done = 1'b0;

  always #5 clk = ~clk;

  des_top dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .plainText (plainText),
    .key       (key),
`ifdef DES_DECRYPT_EN
    .decrypt   (decrypt),
`endif
    .encrypted (encrypted),
    .completed (completed)
  );

  // Reference tables, 1-based DES bit numbers.
  localparam int IP [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int FP [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int E [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
    16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
    10,2,59,51,43,35,27,19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,
    14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,
    16,7,27,20,13,2,41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int S [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}};

  // Textbook DES: whole subkey table first (cumulative rotation), then 16 rounds.
  function automatic logic [63:0] des_ref(input logic [63:0] kv, input logic [63:0] pv,
                                          input bit dec);
    bit pb[1:64], kb[1:64], cd[1:56], ks[1:16][1:48];
    bit l[1:32], r[1:32], t[1:32], sb[1:32], ex[1:48], pre[1:64];
    logic [63:0] res;
    int sh, src, row, col, v, kn;
    for (int i = 1; i <= 64; i++) begin pb[i] = pv[64-i]; kb[i] = kv[64-i]; end
    for (int i = 1; i <= 56; i++) cd[i] = kb[PC1[i-1]];
    sh = 0;
    for (int n = 1; n <= 16; n++) begin
      sh += (n == 1 || n == 2 || n == 9 || n == 16) ? 1 : 2;
      for (int j = 1; j <= 48; j++) begin
        src = PC2[j-1];
        if (src <= 28) ks[n][j] = cd[((src - 1 + sh) % 28) + 1];
        else           ks[n][j] = cd[28 + ((src - 29 + sh) % 28) + 1];
      end
    end
    for (int i = 1; i <= 32; i++) begin l[i] = pb[IP[i-1]]; r[i] = pb[IP[i+31]]; end
    for (int n = 1; n <= 16; n++) begin
      kn = dec ? 17 - n : n;
      for (int j = 1; j <= 48; j++) ex[j] = r[E[j-1]] ^ ks[kn][j];
      for (int b = 0; b < 8; b++) begin
        row = 2 * ex[6*b+1] + ex[6*b+6];
        col = 8 * ex[6*b+2] + 4 * ex[6*b+3] + 2 * ex[6*b+4] + ex[6*b+5];
        v   = S[b][row][col];
        for (int q = 0; q < 4; q++) sb[4*b+1+q] = v[3-q];
      end
      for (int j = 1; j <= 32; j++) t[j] = l[j] ^ sb[P[j-1]];
      l = r;
      r = t;
    end
    for (int i = 1; i <= 32; i++) begin pre[i] = r[i]; pre[i+32] = l[i]; end
    for (int i = 1; i <= 64; i++) res[64-i] = pre[FP[i-1]];
    return res;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Edges since reset release; the completing edge must be number 18.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: pops the scoreboard when completed rises, then checks the hold.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen_done = 1'b0;
      end else if (seen_done) begin
        check("completed held", 64'(completed), 64'd1);
        check("ciphertext held", encrypted, last_ct);
      end else if (completed) begin
        seen_done = 1'b1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected completion: got %h, expected none", encrypted);
        end else begin
          last_ct = exp_q.pop_front();
          check("ciphertext", encrypted, last_ct);
          check("latency", 64'(cyc), 64'd18);
        end
      end else begin
        check("no partial result", encrypted, 64'd0);
      end
    end
  end

  // One operation: reset (checking the async clear), load inputs, release, wait.
  task automatic run_op(input logic [63:0] k, input logic [63:0] pt, input logic [63:0] exp,
                        input bit dec, input bit disturb, input int abort_at);
    rst_n = 1'b0;
    #1;
    check("reset encrypted", encrypted, 64'd0);
    check("reset completed", 64'(completed), 64'd0);
    key       = k;
    plainText = pt;
`ifdef DES_DECRYPT_EN
    decrypt = dec;
`endif
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    rst_n = 1'b1;
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #1;
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      #1;
      check("abort encrypted", encrypted, 64'd0);
      check("abort completed", 64'(completed), 64'd0);
      return;
    end
    if (disturb) begin
      repeat (5) @(posedge clk);
      #1;
      plainText = {$urandom(), $urandom()};
      key       = {$urandom(), $urandom()};
`ifdef DES_DECRYPT_EN
      decrypt = ~dec;
`endif
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL completion timeout: got completed=%0b, expected 1", completed);
      exp_q.delete();
    end
    // Inputs wiggle while DONE holds; the monitor checks nothing moves.
    for (int i = 0; i < 4; i++) begin
      plainText = {$urandom(), $urandom()};
      key       = {$urandom(), $urandom()};
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [63:0] rk, rp;
    bit          rd;
    repeat (2) @(posedge clk);
    #1;
    run_op(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 1'b0, 1'b0, 0);
    run_op(64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7, 1'b0, 1'b0, 0);
    run_op(64'h0101010101010101, 64'h8000000000000000, 64'h95F8A5E5DD31D900, 1'b0, 1'b0, 0);
    run_op(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 1'b0, 1'b1, 0);
    run_op(64'h1122334455667788, 64'hFEDCBA9876543210,
           des_ref(64'h1122334455667788, 64'hFEDCBA9876543210, 1'b0), 1'b0, 1'b0, 8);
    run_op(64'h1122334455667788, 64'h00DCB00006543210,
           des_ref(64'h1122334455667788, 64'h00DCB00006543210, 1'b0), 1'b0, 1'b0, 0);
    if (HasDec) begin
      run_op(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 1'b1, 1'b0, 0);
    end
    for (int n = 0; n < 10; n++) begin
      rk = {$urandom(), $urandom()};
      rp = {$urandom(), $urandom()};
      rd = HasDec ? 1'($urandom_range(1)) : 1'b0;
      run_op(rk, rp, des_ref(rk, rp, rd), rd, 1'($urandom_range(1)), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
